// File: rtl/uart_cmd_resp_if.sv
// Parallel side of the UART command/response block: assembled command out,
// response byte and its send request in.
interface uart_cmd_resp_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  modport master (
    input  cmd, cmd_rdy, tx_done,
    output clr_cmd_rdy, resp, trmt
  );

  modport slave (
    output cmd, cmd_rdy, tx_done,
    input  clr_cmd_rdy, resp, trmt
  );
endinterface

// File: rtl/uart_cmd_resp.sv
// 8N1 UART that assembles two received bytes into a 16-bit command and
// independently transmits a one-byte response.
module uart_cmd_resp #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           RX,
  output logic           TX,
  uart_cmd_resp_if.slave bus
);
  localparam logic [15:0] BaudMax  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BaudHalf = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic {RxIdle, RxRecv} rx_state_e;
  typedef enum logic {AsmHi, AsmLo} asm_state_e;
  typedef enum logic {TxIdle, TxSend} tx_state_e;

  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]  r_sync_fill;
  rx_state_e   r_rx_state;
  asm_state_e  r_asm_state;
  logic [15:0] r_rx_baud;
  logic [3:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;

  tx_state_e   r_tx_state;
  logic [15:0] r_tx_baud;
  logic [3:0]  r_tx_bit;
  logic [8:0]  r_tx_shift;
  logic        r_tx;
  logic        r_tx_done;

  logic        w_rx_fall;

  // Edges are trusted only once the flops hold real line samples, so a line
  // that is low when reset releases is not mistaken for a start bit.
  assign w_rx_fall = (r_sync_fill == 2'd3) & r_rx_prev & ~r_rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_sync_fill <= 2'd0;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (r_sync_fill != 2'd3) r_sync_fill <= r_sync_fill + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state  <= RxIdle;
      r_asm_state <= AsmHi;
      r_rx_baud   <= 16'd0;
      r_rx_bit    <= 4'd0;
      r_rx_shift  <= 8'd0;
      r_cmd       <= 16'd0;
      r_cmd_rdy   <= 1'b0;
    end else begin
      // A set later in this block overrides the clear.
      if (bus.clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      unique case (r_rx_state)
        RxIdle: begin
          if (w_rx_fall) begin
            r_rx_state <= RxRecv;
            r_rx_baud  <= BaudHalf;
            r_rx_bit   <= 4'd0;
          end
        end
        RxRecv: begin
          if (r_rx_baud != 16'd0) begin
            r_rx_baud <= r_rx_baud - 16'd1;
          end else begin
            r_rx_baud <= BaudMax;
            r_rx_bit  <= r_rx_bit + 4'd1;
            if (r_rx_bit == 4'd0) begin
              if (r_rx_sync) r_rx_state <= RxIdle;
            end else if (r_rx_bit != 4'd9) begin
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end else begin
              r_rx_state <= RxIdle;
              if (!r_rx_sync) begin
                r_asm_state <= AsmHi;
              end else if (r_asm_state == AsmHi) begin
                r_cmd[15:8] <= r_rx_shift;
                r_cmd_rdy   <= 1'b0;
                r_asm_state <= AsmLo;
              end else begin
                r_cmd[7:0]  <= r_rx_shift;
                r_cmd_rdy   <= 1'b1;
                r_asm_state <= AsmHi;
              end
            end
          end
        end
        default: r_rx_state <= RxIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TxIdle;
      r_tx_baud  <= 16'd0;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= 9'h1ff;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      unique case (r_tx_state)
        TxIdle: begin
          if (bus.trmt) begin
            r_tx_shift <= {1'b1, bus.resp};
            r_tx       <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_baud  <= BaudMax;
            r_tx_bit   <= 4'd0;
            r_tx_state <= TxSend;
          end
        end
        TxSend: begin
          if (r_tx_baud != 16'd0) begin
            r_tx_baud <= r_tx_baud - 16'd1;
          end else begin
            r_tx_baud <= BaudMax;
            if (r_tx_bit == 4'd9) begin
              r_tx_state <= TxIdle;
              r_tx_done  <= 1'b1;
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[8:1]};
              r_tx_bit   <= r_tx_bit + 4'd1;
            end
          end
        end
        default: r_tx_state <= TxIdle;
      endcase
    end
  end

  assign TX          = r_tx;
  assign bus.cmd     = r_cmd;
  assign bus.cmd_rdy = r_cmd_rdy;
  assign bus.tx_done = r_tx_done;
endmodule

// File: tb/tb_uart_cmd_resp.sv
// Scoreboard bench for uart_cmd_resp: expected commands and response bytes
// are queued when stimulus is driven and checked as the DUT produces them.
`timescale 1ns/1ps
module tb_uart_cmd_resp;
  localparam int unsigned BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic tx;
  logic rx_line;

  uart_cmd_resp_if bus ();

  assign rx_line = loop_en ? tx : rx_drv;

  uart_cmd_resp #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx_line),
    .TX  (tx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_rise = 0;
  logic [15:0] cmd_q[$];
  logic [7:0]  tx_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: plain; 1: check cmd_rdy timing in the stop bit; 2: hold clr over the set cycle
  task automatic send_byte(input logic [7:0] b, input bit stop, input int mode);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      if (i == 9 && mode == 1) begin
        tick(BD / 2);
        check_eq("rdy_early", bus.cmd_rdy, 1'b0);
        tick(5);
        check_eq("rdy_late", bus.cmd_rdy, 1'b1);
        tick(BD - BD / 2 - 5);
      end else if (i == 9 && mode == 2) begin
        bit seen;
        seen = 1'b0;
        bus.clr_cmd_rdy = 1'b1;
        for (int k = 0; k < BD; k++) begin
          tick();
          if (!seen && bus.cmd_rdy === 1'b1) begin
            seen = 1'b1;
            bus.clr_cmd_rdy = 1'b0;
          end
        end
        bus.clr_cmd_rdy = 1'b0;
        check_eq("rdy_set_wins", seen, 1'b1);
        check_eq("rdy_held", bus.cmd_rdy, 1'b1);
      end else begin
        tick(BD);
      end
    end
    rx_drv = 1'b1;
    if (!stop) tick(BD);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 12 * BD && !done; k++) begin
      tick();
      if (bus.tx_done === 1'b1) done = 1'b1;
    end
    check_eq("tx_done_wait", done, 1'b1);
  endtask

  initial begin : rdy_mon
    logic prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cmd_rdy === 1'b1 && prev !== 1'b1) begin
        n_rise++;
        e = (cmd_q.size() > 0) ? cmd_q.pop_front() : 16'hxxxx;
        check_eq("cmd", bus.cmd, e);
      end
      prev = bus.cmd_rdy;
    end
  end

  initial begin : tx_mon
    logic [7:0] d;
    logic [7:0] e;
    logic       stop;
    bit         ab;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b0 && tx === 1'b0) begin
        ab = 1'b0;
        for (int i = 0; i < BD / 2; i++) begin
          @(posedge clk);
          #1;
          if (rst) ab = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
          for (int i = 0; i < BD; i++) begin
            @(posedge clk);
            #1;
            if (rst) ab = 1'b1;
          end
          d[b] = tx;
        end
        for (int i = 0; i < BD; i++) begin
          @(posedge clk);
          #1;
          if (rst) ab = 1'b1;
        end
        stop = tx;
        if (!ab) begin
          e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
          check_eq("tx_byte", d, e);
          check_eq("tx_stop", stop, 1'b1);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [9:0] exp_fr;
    int r0;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.trmt        = 1'b0;

    tick(3);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_cmd", bus.cmd, 16'h0000);
    check_eq("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    check_eq("rst_tx_done", bus.tx_done, 1'b0);
    rst = 1'b0;
    tick(5);

    // Two bytes assemble into one command; clr drops cmd_rdy on the next edge.
    cmd_q.push_back(16'hA53C);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h3C, 1'b1, 1);
    check_eq("cmd_a53c", bus.cmd, 16'hA53C);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    check_eq("clr_next", bus.cmd_rdy, 1'b0);
    tick(BD);

    // Response frame timing, with an ignored second trmt mid-frame.
    exp_fr = {1'b1, 8'h78, 1'b0};
    tx_q.push_back(8'h78);
    bus.resp = 8'h78;
    bus.trmt = 1'b1;
    tick();
    bus.trmt = 1'b0;
    for (int k = 0; k < 10 * BD; k++) begin
      if (k % BD == 0 || k % BD == BD - 1)
        check_eq($sformatf("tx_bit%0d", k / BD), tx, exp_fr[k / BD]);
      if (k == 10 * BD - 1) check_eq("tx_done_early", bus.tx_done, 1'b0);
      if (k == 3 * BD + 2) begin
        bus.resp = 8'hFF;
        bus.trmt = 1'b1;
      end
      if (k == 3 * BD + 3) bus.trmt = 1'b0;
      tick();
    end
    check_eq("tx_done", bus.tx_done, 1'b1);
    tick(2 * BD);
    check_eq("tx_idle", tx, 1'b1);

    // Framing error on the first byte is discarded.
    r0 = n_rise;
    send_byte(8'h77, 1'b0, 0);
    cmd_q.push_back(16'h1234);
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    tick(4);
    check_eq("frame_rise_once", n_rise - r0, 1);
    check_eq("cmd_1234", bus.cmd, 16'h1234);

    // Short low glitch produces no byte.
    r0 = n_rise;
    rx_drv = 1'b0;
    tick(BD / 4);
    rx_drv = 1'b1;
    tick(2 * BD);
    check_eq("glitch_cmd", bus.cmd, 16'h1234);
    check_eq("glitch_rdy", bus.cmd_rdy, 1'b1);
    check_eq("glitch_rise", n_rise - r0, 0);

    // clr held high in the set cycle: set wins.
    cmd_q.push_back(16'h0102);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 2);
    check_eq("cmd_0102", bus.cmd, 16'h0102);
    tick(BD);

    // Reset mid-frame in both directions; line still low when reset releases.
    bus.resp = 8'hC3;
    bus.trmt = 1'b1;
    tick();
    bus.trmt = 1'b0;
    rx_drv = 1'b0;
    tick(5 * BD);
    rst = 1'b1;
    #1;
    check_eq("rst_tx_now", tx, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rst_mid_tx", tx, 1'b1);
      check_eq("rst_mid_cmd", bus.cmd, 16'h0000);
      check_eq("rst_mid_rdy", bus.cmd_rdy, 1'b0);
      check_eq("rst_mid_done", bus.tx_done, 1'b0);
    end
    rst = 1'b0;
    tick(2 * BD);
    rx_drv = 1'b1;
    tick(2 * BD);
    check_eq("post_rst_rdy", bus.cmd_rdy, 1'b0);
    cmd_q.push_back(16'hBEEF);
    send_byte(8'hBE, 1'b1, 0);
    send_byte(8'hEF, 1'b1, 0);
    check_eq("cmd_beef", bus.cmd, 16'hBEEF);
    tick(BD);

    // Loopback: two 0x55 responses become command 0x5555.
    loop_en = 1'b1;
    cmd_q.push_back(16'h5555);
    for (int i = 0; i < 2; i++) begin
      tx_q.push_back(8'h55);
      bus.resp = 8'h55;
      bus.trmt = 1'b1;
      tick();
      bus.trmt = 1'b0;
      wait_done();
      tick(BD);
    end
    check_eq("cmd_5555", bus.cmd, 16'h5555);
    loop_en = 1'b0;

    tick(4);
    check_eq("cmd_q_empty", cmd_q.size(), 0);
    check_eq("tx_q_empty", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_cmd_resp.md
UART_CMD_RESP -- requirements
Module: uart_cmd_resp

Interface
REQ-001 Parameter BAUD_DIV, default 2604, SHALL set the clocks per serial bit (19200 baud at 50 MHz).
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset; it SHALL be asynchronous and active-high.
REQ-004 RX  input  1  serial command in; asynchronous, idles high.
REQ-005 TX  output  1  serial response out; idles high.
REQ-006 cmd  output  16  assembled command; the first byte received is cmd[15:8], the second is cmd[7:0].
REQ-007 cmd_rdy  output  1  high when a complete 16-bit cmd is valid.
REQ-008 clr_cmd_rdy  input  1  synchronous request to drop cmd_rdy.
REQ-009 resp  input  8  response byte to transmit.
REQ-010 trmt  input  1  one-cycle request to send resp.
REQ-011 tx_done  output  1  high after a response frame completes.

Function
REQ-012 Both directions SHALL use the frame format 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_DIV clocks.
REQ-013 RX SHALL pass through a two-flop synchronizer that resets to 1 before any use.
REQ-014 The receiver SHALL have states IDLE and RECV: a synchronized 1->0 edge in IDLE enters RECV.
REQ-015 In RECV the receiver SHALL sample at BAUD_DIV/2 after the start edge, then every BAUD_DIV clocks: 1 start check, 8 data bits, 1 stop bit.
REQ-016 If the start-bit sample is 1, the receiver SHALL return to IDLE with no byte produced (glitch rejection).
REQ-017 If the stop-bit sample is 0 (framing error), the byte SHALL be discarded and the assembler SHALL return to BYTE_HI.
REQ-018 The assembler SHALL have states BYTE_HI and BYTE_LO, reset to BYTE_HI.
REQ-019 A good byte in BYTE_HI SHALL load cmd[15:8], clear cmd_rdy and enter BYTE_LO.
REQ-020 A good byte in BYTE_LO SHALL load cmd[7:0], set cmd_rdy and enter BYTE_HI.
REQ-021 cmd_rdy SHALL be set in the cycle after the stop-bit sample of the second byte.
REQ-022 clr_cmd_rdy SHALL clear cmd_rdy on the next edge; if it coincides with a set, the set SHALL win.
REQ-023 cmd SHALL change only at byte completion; cmd[7:0] SHALL hold while cmd_rdy is high.
REQ-024 The transmitter SHALL have states IDLE and SEND.
REQ-025 trmt in IDLE SHALL latch resp, clear tx_done, enter SEND, and drive the start bit on the next cycle.
REQ-026 trmt while in SEND SHALL be ignored and the latched byte SHALL be unaffected.
REQ-027 After the full stop bit (10*BAUD_DIV clocks from start), the transmitter SHALL return to IDLE and set tx_done, which SHALL stay high until the next accepted trmt.
REQ-028 Receive and transmit paths SHALL operate fully independently and concurrently.
REQ-029 The bit counters SHALL be sized for BAUD_DIV up to 65535 without wrap error.

Reset
REQ-030 While rst is high: TX=1, cmd=0, cmd_rdy=0, tx_done=0, both machines IDLE, assembler BYTE_HI, synchronizer=1.
REQ-031 rst mid-frame SHALL abort both directions immediately; a partial byte SHALL never reach cmd.
REQ-032 After rst deasserts, a mid-frame RX line SHALL be ignored until the next synchronized 1->0 edge.

Verification
REQ-033 Send bytes 0xA5 then 0x3C on RX -> cmd=16'hA53C; cmd_rdy rises within 2 clocks after the second stop-bit sample; clr_cmd_rdy pulse -> cmd_rdy=0 next cycle.
REQ-034 resp=0x78, trmt pulse -> TX carries 0,0,0,0,1,1,1,1,0,1, each bit BAUD_DIV clocks; tx_done=1 at clock 10*BAUD_DIV+1; a second trmt mid-frame has no effect.
REQ-035 Stop bit forced 0 on the first byte, then bytes 0x12, 0x34 -> cmd=16'h1234 and cmd_rdy set exactly once.
REQ-036 RX low pulse of BAUD_DIV/4 clocks -> no byte produced; cmd and assembler state unchanged.
REQ-037 rst asserted mid first byte, then release and send 0xBE, 0xEF -> cmd=16'hBEEF, and TX=1 throughout reset.
REQ-038 clr_cmd_rdy held high in the set cycle of 0x0102 -> cmd_rdy=1; loopback TX to RX with trmt and resp=0x55 twice -> cmd=16'h5555.
